mem_access_seq: RTL
===================

Name: mem_access_seq

Overview:
- Upstream master of the byte-wide memory controller.
- Converts one CPU load/store of 1, 2 or 4 bytes into a sequence of single-byte bus beats on the controller's 8-bit readmem/writemem/addressBus/dataBus interface, little-endian.
- Assembles load results with zero- or sign-extension and returns one 32-bit result per request through a req/done handshake.
- Sits between the CPU datapath/fetch unit and the memory controller.

Parameters:
- dataWidth, 8, byte-bus width; fixed at 8, other values unsupported.
- addressWidth, 32, address width on both sides.
- wordWidth, 32, CPU data width; must equal 4*dataWidth.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  1  CPU request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sign_ext  input  1  load only: 1 sign-extends, 0 zero-extends.
- addr  input  addressWidth  CPU byte address.
- wdata  input  wordWidth  store data; low size bytes used.
- busy  output  1  high from acceptance until done.
- done  output  1  one-cycle completion pulse.
- rdata  output  wordWidth  load result; valid while done=1, held until next acceptance.
- err  output  1  valid with done; see Optional Feature.
- readmem  output  1  byte-read strobe to controller.
- writemem  output  1  byte-write strobe to controller.
- addressBus  output  addressWidth  beat address.
- dataBusOut  output  dataWidth  byte written on store beats.
- dataBusIn  input  dataWidth  byte returned by controller.
- memDataReady  input  1  controller beat-complete.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, err, readmem, writemem = 0; addressBus, dataBusOut, rdata = 0; beat counter = 0.
- An in-flight sequence is abandoned; no partial beat completes.
- FSM states: IDLE, BEAT, DONE.
- IDLE, req=1:
  - Latch addr, we, size, sign_ext and wdata.
  - Set beat count N: byte=1, half=2, word/reserved=4.
  - Set busy=1; go to BEAT with k=0.
- IDLE, req=0: stay in IDLE.
- BEAT, drive outputs:
  - addressBus = latched addr + k, modulo 2^addressWidth (wraps from FFFF_FFFF to 0).
  - readmem = ~we, writemem = we.
  - dataBusOut = wdata[8k+7:8k] on stores, 0 on loads.
- BEAT, memDataReady=0 at the edge: hold all outputs (wait state, unbounded).
- BEAT, memDataReady=1 at the edge:
  - Load: capture dataBusIn into byte lane k.
  - If k=N-1, go to DONE; otherwise k=k+1.
  - With memDataReady tied high, each beat takes exactly one cycle.
- DONE:
  - done=1 and busy=1 for exactly one cycle; readmem=writemem=0.
  - rdata = assembled bytes, upper bits filled from bit 8N-1 if sign_ext, else 0.
  - Stores leave rdata unchanged.
  - Next state IDLE; busy drops.
- Latency: done asserts N+1 cycles after the accepting edge (word = 5 cycles, byte = 2 cycles).
- Minimum request spacing is N+2 cycles.
- req held high through DONE is re-accepted in the following IDLE cycle; no request is queued while busy.
- Simultaneous req with rst=0: reset wins; nothing is latched.
- No alignment check or splitting beyond the byte sequence; unaligned accesses are performed byte-wise.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: at acceptance, half with addr[0]=1 or word with addr[1:0]!=0 skips BEAT and goes straight to DONE.
  - No bus strobes are issued.
  - err=1 with done; rdata unchanged.
  - Aligned accesses behave exactly as without the macro.
- Undefined: err tied 0; unaligned accesses are performed byte-wise.

Decomposition:
- Shared package (mem_pkg): state encoding IDLE/BEAT/DONE, size codes SZ_BYTE/SZ_HALF/SZ_WORD, controller region base constants 32'h0000_0000, 32'h0010_0000, 32'h0100_0000, 32'h1000_0000 for bench use.
- Sub-module: mem_access_extend, a combinational size/sign extension of the assembled word. All other logic lives in the top.

Test Plan:
- Word store: addr=32'h0010_0004, wdata=32'hA1B2C3D4, memDataReady=1 -> writes 0xD4,0xC3,0xB2,0xA1 at 0x0010_0004..0007 on consecutive cycles; done 5 cycles after acceptance.
- Word load after the store: same addr -> rdata=32'hA1B2C3D4 with done; readmem high for exactly 4 cycles.
- Byte load 0x80 at 0x0010_0010: sign_ext=1 -> rdata=32'hFFFF_FF80; sign_ext=0 -> 32'h0000_0080. Half load 0x8001 with sign_ext=1 -> 32'hFFFF_8001.
- Wait states: memDataReady low for 3 cycles on beat 2 of a word load -> addressBus holds addr+2, done delayed 3 cycles, data correct.
- Reset mid-word-store after 2 beats: rst=0 -> all outputs 0 immediately, no done; next request runs normally. Address wrap: word store at 32'hFFFF_FFFE -> beat addresses FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- With MEM_ACCESS_ALIGN_CHECK_EN: word load at 32'h0010_0002 -> no strobes, done+err 1 cycle after acceptance; aligned load at 0x0010_0004 -> err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wise memory access sequencer.
// Contents: FSM state encoding, access size codes, controller region bases and size helpers.
package mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BEAT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Base addresses of the memory controller's regions.
  localparam logic [31:0] REGION0_BASE = 32'h0000_0000;
  localparam logic [31:0] REGION1_BASE = 32'h0010_0000;
  localparam logic [31:0] REGION2_BASE = 32'h0100_0000;
  localparam logic [31:0] REGION3_BASE = 32'h1000_0000;

  // Index of the final beat: byte=0, half=1, word and reserved=3.
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// CPU request/response handshake plus the byte-wide controller bus of mem_access_seq.
// The master modport is the sequencer; slave is the CPU/controller environment.
interface mem_access_seq_if #(
  parameter int dataWidth    = 8,
  parameter int addressWidth = 32,
  parameter int wordWidth    = 32
);
  // CPU side
  logic                    req;
  logic                    we;
  logic [1:0]              size;
  logic                    sign_ext;
  logic [addressWidth-1:0] addr;
  logic [wordWidth-1:0]    wdata;
  logic                    busy;
  logic                    done;
  logic [wordWidth-1:0]    rdata;
  logic                    err;

  // Controller side
  logic                    readmem;
  logic                    writemem;
  logic [addressWidth-1:0] addressBus;
  logic [dataWidth-1:0]    dataBusOut;
  logic [dataWidth-1:0]    dataBusIn;
  logic                    memDataReady;

  modport master (
    input  req, we, size, sign_ext, addr, wdata, dataBusIn, memDataReady,
    output busy, done, rdata, err, readmem, writemem, addressBus, dataBusOut
  );

  modport slave (
    output req, we, size, sign_ext, addr, wdata, dataBusIn, memDataReady,
    input  busy, done, rdata, err, readmem, writemem, addressBus, dataBusOut
  );
endinterface

// File: rtl/mem_access_extend.sv
// Size-dependent zero/sign extension of a little-endian assembled load word.
module mem_access_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result unassigned and no latch is inferred.
    result = word;
    case (size)
      SZ_BYTE: result = {{24{sign_ext & word[7]}}, word[7:0]};
      SZ_HALF: result = {{16{sign_ext & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Splits one 1/2/4-byte CPU load/store into little-endian byte beats on the controller bus.
// Optional MEM_ACCESS_ALIGN_CHECK_EN: misaligned half/word requests complete at once with err=1.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int dataWidth    = 8,
  parameter int addressWidth = 32,
  parameter int wordWidth    = 32
) (
  input logic               clk,
  input logic               rst,
  mem_access_seq_if.master  bus
);

  logic [1:0]              state_q;
  logic [1:0]              k_q;
  logic [1:0]              last_q;
  logic [addressWidth-1:0] addr_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    sext_q;
  logic [wordWidth-1:0]    wdata_q;
  logic [wordWidth-1:0]    asm_q;
  logic [wordWidth-1:0]    asm_nxt;
  logic [wordWidth-1:0]    ext_word;
  logic [wordWidth-1:0]    rdata_q;
  logic                    misaligned;
  logic                    in_beat;

  assign in_beat = (state_q == ST_BEAT);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = is_misaligned(bus.size, bus.addr[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              err_q <= 1'b0;
    else if (state_q == ST_IDLE && bus.req) err_q <= misaligned;
  end

  assign bus.err = (state_q == ST_DONE) && err_q;
`else
  assign misaligned = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Assembled word including the byte arriving on the current beat, so the
  // final beat's byte is already present when rdata is loaded.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{k_q, 3'b000} +: dataWidth] = bus.dataBusIn;
  end

  mem_access_extend u_extend (
    .word     (asm_nxt),
    .size     (size_q),
    .sign_ext (sext_q),
    .result   (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q <= ST_IDLE;
      k_q     <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            size_q  <= bus.size;
            sext_q  <= bus.sign_ext;
            wdata_q <= bus.wdata;
            asm_q   <= '0;
            k_q     <= '0;
            last_q  <= last_beat(bus.size);
            state_q <= misaligned ? ST_DONE : ST_BEAT;
          end
        end
        ST_BEAT: begin
          // Without memDataReady every register holds: an unbounded wait state.
          if (bus.memDataReady) begin
            if (!we_q) asm_q <= asm_nxt;
            if (k_q == last_q) begin
              state_q <= ST_DONE;
              if (!we_q) rdata_q <= ext_word;
            end else begin
              k_q <= k_q + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          k_q     <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.rdata      = rdata_q;
  assign bus.readmem    = in_beat && !we_q;
  assign bus.writemem   = in_beat && we_q;
  assign bus.addressBus = in_beat ? addr_q + addressWidth'(k_q) : '0;
  assign bus.dataBusOut = (in_beat && we_q) ? wdata_q[{k_q, 3'b000} +: dataWidth] : '0;

endmodule
